// File: rtl/pwm_ctrl_pkg.sv
// Shared types, default widths and the saturating duty-step helper for the
// PWM fade sequencer.
package pwm_ctrl_pkg;

  localparam int PWM_WIDTH      = 16;
  localparam int PWM_INTERVAL_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    UP   = 2'd2,
    DOWN = 2'd3
  } fade_state_t;

  // Next duty one step toward target, clamped so it never passes the target,
  // wraps above full scale or underflows below zero.
  function automatic logic [PWM_WIDTH-1:0] sat_step(
    input logic [PWM_WIDTH-1:0] cur,
    input logic [PWM_WIDTH-1:0] step,
    input logic [PWM_WIDTH-1:0] target,
    input logic                 down
  );
    logic [PWM_WIDTH:0]   sum;
    logic [PWM_WIDTH-1:0] diff;
    logic [PWM_WIDTH-1:0] res;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = cur - step;
    if (!down) begin
      res = (sum > {1'b0, target}) ? target : sum[PWM_WIDTH-1:0];
    end else if (cur < step) begin
      res = target;
    end else begin
      res = (diff < target) ? target : diff;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Period boundary tracker: counts clk cycles within a PWM period and flags the
// last one; period_start marks the first cycle of every new period.
module pwm_period_tick
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             restart,
  input  logic [WIDTH-1:0] period,
  output logic             boundary,
  output logic             period_start
);

  logic [WIDTH-1:0] pcnt;
  logic             start_q;

  // Periods of 0 or 1 make every cycle a boundary; this also keeps period-1
  // from wrapping.
  assign boundary = (period <= WIDTH'(1)) || (pcnt == period - WIDTH'(1));

  always_ff @(posedge clk) begin
    if (restart) begin
      pcnt    <= '0;
      start_q <= 1'b0;
    end else begin
      pcnt    <= boundary ? '0 : pcnt + WIDTH'(1);
      start_q <= boundary;
    end
  end

  assign period_start = start_q & ~restart;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer: accepts ramp commands and steps the PWM duty toward a target,
// updating duty/period only on period boundaries.
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH          = PWM_WIDTH,
  parameter int INTERVAL_W     = PWM_INTERVAL_W,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_period,
  input  logic [WIDTH-1:0]      cfg_target,
  input  logic [WIDTH-1:0]      cfg_step,
  input  logic [INTERVAL_W-1:0] cfg_interval,
  output logic [WIDTH-1:0]      duty_cycle,
  output logic [WIDTH-1:0]      period,
  output logic                  period_start,
  output logic                  busy,
  output logic                  done,
  output fade_state_t           state
);

  // Handshake: a command transfers on any rising clk edge where cfg_valid and
  // cfg_ready are both high; cfg_ready is high only in IDLE, so commands that
  // arrive while a ramp is pending or running simply wait.

  fade_state_t           state_q, state_n;
  logic [WIDTH-1:0]      duty_q, duty_n;
  logic [WIDTH-1:0]      period_q, period_n;
  logic [WIDTH-1:0]      tgt_q, tgt_n;
  logic [WIDTH-1:0]      stp_q, stp_n;
  logic [WIDTH-1:0]      new_per_q, new_per_n;
  logic [INTERVAL_W-1:0] ivl_q, ivl_n;
  logic [INTERVAL_W-1:0] icnt_q, icnt_n;
  logic                  done_q, done_n;
  logic [WIDTH-1:0]      stepped;
  logic                  boundary;

  pwm_period_tick #(.WIDTH(WIDTH)) u_tick (
    .clk          (clk),
    .restart      (rst),
    .period       (period_q),
    .boundary     (boundary),
    .period_start (period_start)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      period_q  <= WIDTH'(DEFAULT_PERIOD);
      tgt_q     <= '0;
      stp_q     <= '0;
      new_per_q <= '0;
      ivl_q     <= '0;
      icnt_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      duty_q    <= duty_n;
      period_q  <= period_n;
      tgt_q     <= tgt_n;
      stp_q     <= stp_n;
      new_per_q <= new_per_n;
      ivl_q     <= ivl_n;
      icnt_q    <= icnt_n;
      done_q    <= done_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    duty_n    = duty_q;
    period_n  = period_q;
    tgt_n     = tgt_q;
    stp_n     = stp_q;
    new_per_n = new_per_q;
    ivl_n     = ivl_q;
    icnt_n    = icnt_q;
    done_n    = 1'b0;
    stepped   = sat_step(duty_q, stp_q, tgt_q, state_q == DOWN);
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          // Target is clamped to 100% of the new period; a zero step would stall.
          tgt_n     = (cfg_target > cfg_period) ? cfg_period : cfg_target;
          stp_n     = (cfg_step == '0) ? WIDTH'(1) : cfg_step;
          ivl_n     = cfg_interval;
          new_per_n = cfg_period;
          state_n   = PEND;
        end
      end
      PEND: begin
        if (boundary) begin
          period_n = new_per_q;
          icnt_n   = '0;
          if (tgt_q > duty_q) begin
            state_n = UP;
          end else if (tgt_q < duty_q) begin
            state_n = DOWN;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      UP, DOWN: begin
        if (boundary) begin
          if (icnt_q == ivl_q) begin
            icnt_n = '0;
            duty_n = stepped;
            if (stepped == tgt_q) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            icnt_n = icnt_q + INTERVAL_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = done_q & ~rst;
  assign duty_cycle = duty_q;
  assign period     = period_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: directed ramps plus random commands, each checked
// against a per-period schedule of expected duty values.
module tb_pwm_fade_ctrl;
  import pwm_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [W-1:0]  cfg_period = '0;
  logic [W-1:0]  cfg_target = '0;
  logic [W-1:0]  cfg_step = '0;
  logic [IW-1:0] cfg_interval = '0;
  logic [W-1:0]  duty_cycle;
  logic [W-1:0]  period;
  logic          period_start;
  logic          busy;
  logic          done;
  fade_state_t   state;

  int total = 0;
  int bad   = 0;
  int m_duty   = 0;
  int m_period = 1000;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.WIDTH(W), .INTERVAL_W(IW), .DEFAULT_PERIOD(1000)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_target   (cfg_target),
    .cfg_step     (cfg_step),
    .cfg_interval (cfg_interval),
    .duty_cycle   (duty_cycle),
    .period       (period),
    .period_start (period_start),
    .busy         (busy),
    .done         (done),
    .state        (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One-cycle reset; outputs are checked while rst is still high.
  task automatic pulse_reset();
    @(negedge clk);
    rst       = 1'b1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("rst_duty", 32'(duty_cycle), 0);
    check("rst_period", 32'(period), 1000);
    check("rst_pstart", 32'(period_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_state", 32'(state), 32'(IDLE));
    rst      = 1'b0;
    m_duty   = 0;
    m_period = 1000;
  endtask

  // Issue one command and follow it period by period. The model is a schedule:
  // the first period_start after acceptance applies the period, then every
  // (iv+1)-th period_start carries the next entry of exp_q.
  task automatic do_cmd(input int p, input int t, input int s, input int iv,
                        input bit hold, input int abort_at);
    int tc, sc, v, npulse, pulse, since, limit, cyc, cur_d, cur_p;
    logic [W-1:0] exp_q[$];
    tc = (t > p) ? p : t;
    sc = (s == 0) ? 1 : s;
    v  = m_duty;
    exp_q = {};
    while (v != tc) begin
      if (tc > v) v = (v + sc > tc) ? tc : v + sc;
      else        v = (v < sc) ? tc : ((v - sc < tc) ? tc : v - sc);
      exp_q.push_back(W'(v));
    end
    npulse = 1 + exp_q.size() * (iv + 1);

    @(negedge clk);
    check("ready_idle", 32'(cfg_ready), 1);
    cfg_valid    = 1'b1;
    cfg_period   = W'(p);
    cfg_target   = W'(t);
    cfg_step     = W'(s);
    cfg_interval = IW'(iv);
    @(negedge clk);
    if (!hold) cfg_valid = 1'b0;
    check("ready_drop", 32'(cfg_ready), 0);
    check("busy_rise", 32'(busy), 1);
    check("pend_duty", 32'(duty_cycle), 32'(m_duty));
    check("pend_period", 32'(period), 32'(m_period));

    cur_d = m_duty;
    cur_p = m_period;
    pulse = 0;
    since = 0;
    cyc   = 0;
    limit = 1100 + npulse * (p + 3);
    while (pulse < npulse && cyc < limit) begin
      @(negedge clk);
      cyc++;
      since++;
      if (period_start) begin
        pulse++;
        if (pulse == 1) cur_p = p;
        else check("spacing", since, (p < 1) ? 1 : p);
        since = 0;
        if (pulse > 1 && (pulse - 1) % (iv + 1) == 0)
          cur_d = int'(exp_q[(pulse - 1) / (iv + 1) - 1]);
        check("duty_at_tick", 32'(duty_cycle), cur_d);
        check("period_at_tick", 32'(period), cur_p);
        check("done_at_tick", 32'(done), 32'(pulse == npulse));
        check("busy_at_tick", 32'(busy), 32'(pulse != npulse));
        if (pulse == npulse) cfg_valid = 1'b0;
        if (abort_at >= 0 && cur_d == abort_at && pulse != npulse) begin
          pulse_reset();
          return;
        end
      end else begin
        check("duty_hold", 32'(duty_cycle), cur_d);
        check("period_hold", 32'(period), cur_p);
        check("done_quiet", 32'(done), 0);
        check("ready_low", 32'(cfg_ready), 0);
      end
    end
    if (pulse < npulse) begin
      check("ramp_timeout", pulse, npulse);
      pulse_reset();
      return;
    end
    m_duty   = tc;
    m_period = p;
    @(negedge clk);
    check("done_once", 32'(done), 0);
    check("busy_after", 32'(busy), 0);
    check("ready_after", 32'(cfg_ready), 1);
    check("state_after", 32'(state), 32'(IDLE));
  endtask

  initial begin
    int n;
    pulse_reset();

    // Default 1000-cycle period: first period_start 1000 cycles after reset.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 1500);
    check("first_pstart", n, 1000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 1500);
    check("pstart_spacing", n, 1000);

    do_cmd(10, 6, 2, 0, 1'b0, -1);  // 0->2->4->6
    do_cmd(10, 0, 4, 1, 1'b0, -1);  // 6->2->0, every 2 periods
    do_cmd(8, 20, 0, 0, 1'b0, -1);  // clamp to 8, step 1
    do_cmd(6, 0, 2, 1, 1'b1, -1);   // cfg_valid held through the ramp
    do_cmd(10, 8, 2, 0, 1'b0, 4);   // reset when duty reaches 4
    do_cmd(10, 5, 3, 0, 1'b0, -1);  // fresh command after reset

    for (int i = 0; i < 15; i++) begin
      do_cmd($urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 5),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
